// File: rtl/fifo_push_arbiter.sv
// fifo_push_arbiter
//   Round-robin, burst-locked arbiter sharing the single push port of the
//   downstream FIFO among NUM_REQ requesters using a valid/grant handshake.
//   Ownership is held for up to MAX_BURST transfers, then rotates.
//
// Ports
//   clk, rst_n     : clock (posedge) and asynchronous active-low reset
//   req_valid_i    : per-requester valid
//   req_data_i     : packed requester data, requester k at [k*(DATA_WIDTH+1) +: DATA_WIDTH+1]
//   req_grant_o    : per-requester grant (combinational from push_grant_i)
//   push_valid_o   : valid towards the FIFO push port
//   push_data_o    : owner's data towards the FIFO push port
//   push_grant_i   : grant from the FIFO push port
//   owner_o        : current owner index, meaningful while busy_o is 1
//   busy_o         : 1 while an owner holds the port
`timescale 1ns/1ps

module fifo_push_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 4,
    parameter int MAX_BURST  = 4
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [NUM_REQ-1:0]                  req_valid_i,
    input  logic [NUM_REQ*(DATA_WIDTH+1)-1:0]   req_data_i,
    output logic [NUM_REQ-1:0]                  req_grant_o,
    output logic                                push_valid_o,
    output logic [DATA_WIDTH:0]                 push_data_o,
    input  logic                                push_grant_i,
    output logic [$clog2(NUM_REQ)-1:0]          owner_o,
    output logic                                busy_o
);

    localparam int OW = $clog2(NUM_REQ);
    localparam int CW = $clog2(MAX_BURST + 1);
    localparam int DW = DATA_WIDTH + 1;

    typedef enum logic {
        IDLE,
        OWN
    } state_t;

    state_t          state;
    logic [OW-1:0]   owner;
    logic [OW-1:0]   last;
    logic [CW-1:0]   burst_cnt;

    logic [OW-1:0]   pick;
    logic            pick_found;
    logic            owner_valid;
    logic            xfer;
    logic            release_own;

    // Scan from last+1 upward with wrap; last is the previous owner, so it
    // is naturally visited last. Under a burst-limit release the owner is
    // therefore only re-picked when no other requester is valid.
    always_comb begin
        pick       = last;
        pick_found = 1'b0;
        for (int unsigned i = 1; i <= NUM_REQ; i++) begin
            if (!pick_found && req_valid_i[OW'((32'(last) + i) % NUM_REQ)]) begin
                pick_found = 1'b1;
                pick       = OW'((32'(last) + i) % NUM_REQ);
            end
        end
    end

    assign owner_valid = req_valid_i[owner];

    always_comb begin
        req_grant_o  = '0;
        push_valid_o = 1'b0;
        push_data_o  = '0;
        if (state == OWN) begin
            push_valid_o       = owner_valid;
            push_data_o        = req_data_i[int'(owner)*DW +: DW];
            req_grant_o[owner] = push_grant_i && owner_valid;
        end
    end

    assign xfer        = push_valid_o && push_grant_i;
    assign release_own = !owner_valid || (xfer && (burst_cnt == CW'(MAX_BURST - 1)));

    assign busy_o  = (state == OWN);
    assign owner_o = owner;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= OW'(NUM_REQ - 1);
            burst_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req_valid_i) begin
                        state     <= OWN;
                        owner     <= pick;
                        last      <= pick;
                        burst_cnt <= '0;
                    end
                end
                OWN: begin
                    if (release_own) begin
                        burst_cnt <= '0;
                        // Same-edge handoff avoids a bubble between owners.
                        if (pick_found) begin
                            owner <= pick;
                            last  <= pick;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (xfer) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_push_arbiter.sv
// tb_fifo_push_arbiter
//   Self-checking bench for fifo_push_arbiter. A behavioural FIFO of depth 4
//   drives push_grant_i; requesters obey the hold-until-granted rule and push
//   each presented word into a scoreboard that is checked on every transfer.
`timescale 1ns/1ps

module tb_fifo_push_arbiter;

    localparam int DW    = 32;
    localparam int NR    = 4;
    localparam int MB    = 4;
    localparam int W     = DW + 1;
    localparam int DEPTH = 4;

    logic            clk = 1'b0;
    logic            rst_n;
    logic [NR-1:0]   req_valid_i;
    logic [NR*W-1:0] req_data_i;
    logic [NR-1:0]   req_grant_o;
    logic            push_valid_o;
    logic [W-1:0]    push_data_o;
    logic            push_grant_i;
    logic [1:0]      owner_o;
    logic            busy_o;

    fifo_push_arbiter #(
        .DATA_WIDTH (DW),
        .NUM_REQ    (NR),
        .MAX_BURST  (MB)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid_i  (req_valid_i),
        .req_data_i   (req_data_i),
        .req_grant_o  (req_grant_o),
        .push_valid_o (push_valid_o),
        .push_data_o  (push_data_o),
        .push_grant_i (push_grant_i),
        .owner_o      (owner_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           req;
        logic [W-1:0] data;
    } sb_t;

    int           n_total = 0;
    int           n_pass  = 0;
    int           remaining [NR];
    int           duty      [NR];
    int           pop_pct;
    logic [W-1:0] nxt       [NR];
    logic [W-1:0] fifo_q [$];
    sb_t          sb     [$];
    int           hist   [$];
    int           hist_cyc [$];
    int           cyc;
    int           wait_oth  [NR];
    int           max_wait;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    // Requesters raise valid with fresh data only when not already waiting.
    task automatic refill();
        for (int k = 0; k < NR; k++) begin
            if (!req_valid_i[k] && remaining[k] > 0 && int'($urandom_range(99)) < duty[k]) begin
                nxt[k]               = nxt[k] + W'(k + 1);
                req_data_i[k*W +: W] = nxt[k];
                req_valid_i[k]       = 1'b1;
                sb.push_back('{req: k, data: nxt[k]});
                remaining[k]--;
            end
        end
        push_grant_i = (fifo_q.size() < DEPTH);
    endtask

    // Called at posedge+1; samples mid-cycle, then advances one clock.
    task automatic tick();
        logic [NR-1:0] g;
        logic [NR-1:0] mask;
        logic          x;
        logic [W-1:0]  d;
        int            k;
        int            idx;
        bit            pop;
        #4;
        g    = req_grant_o;
        x    = push_valid_o && push_grant_i;
        d    = push_data_o;
        mask = busy_o ? (NR'(1) << owner_o) : '0;
        check("grant_vec", 64'(g), x ? 64'(mask) : 64'd0);
        k = -1;
        for (int j = 0; j < NR; j++) if (g[j]) k = j;
        if (x && k >= 0) begin
            idx = -1;
            for (int i = 0; i < sb.size(); i++) if (idx < 0 && sb[i].req == k) idx = i;
            check("sb_entry_found", 64'(idx >= 0), 64'd1);
            if (idx >= 0) begin
                check($sformatf("data_req%0d", k), 64'(d), 64'(sb[idx].data));
                sb.delete(idx);
            end
            hist.push_back(k);
            hist_cyc.push_back(cyc);
        end
        for (int j = 0; j < NR; j++) begin
            if (!req_valid_i[j] || g[j]) wait_oth[j] = 0;
            else if (x) begin
                wait_oth[j]++;
                if (wait_oth[j] > max_wait) max_wait = wait_oth[j];
            end
        end
        pop = int'($urandom_range(99)) < pop_pct;
        @(posedge clk);
        #1;
        cyc++;
        if (x) begin
            fifo_q.push_back(d);
            if (k >= 0) req_valid_i[k] = 1'b0;
        end
        if (pop && fifo_q.size() > 0) void'(fifo_q.pop_front());
        refill();
    endtask

    task automatic clear_model();
        for (int k = 0; k < NR; k++) begin
            remaining[k] = 0;
            duty[k]      = 100;
            nxt[k]       = '0;
            wait_oth[k]  = 0;
        end
        pop_pct = 100;
        max_wait = 0;
        fifo_q.delete();
        sb.delete();
        hist.delete();
        hist_cyc.delete();
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},  64'(busy_o),       64'd0);
        check({tag, "_pval"},  64'(push_valid_o), 64'd0);
        check({tag, "_grant"}, 64'(req_grant_o),  64'd0);
        check({tag, "_data"},  64'(push_data_o),  64'd0);
        check({tag, "_owner"}, 64'(owner_o),      64'd0);
    endtask

    // Called at posedge+1; full reset with all requesters idle.
    task automatic start_test();
        rst_n        = 1'b0;
        req_valid_i  = '0;
        req_data_i   = '0;
        push_grant_i = 1'b0;
        clear_model();
        #1;
        check_idle_outputs("rst");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int n0;
        rst_n        = 1'b0;
        req_valid_i  = '0;
        req_data_i   = '0;
        push_grant_i = 1'b0;
        cyc          = 0;
        clear_model();
        @(posedge clk);
        #1;

        // Single requester: req2 streams 3,6,9,...
        start_test();
        remaining[2] = 8;
        refill();
        tick();
        check("single_owner", 64'(owner_o), 64'd2);
        check("single_busy",  64'(busy_o),  64'd1);
        for (int i = 0; i < 8; i++) tick();
        check("single_count", 64'(hist.size()), 64'd8);
        for (int i = 0; i < hist.size(); i++) check("single_req", 64'(hist[i]), 64'd2);
        if (hist.size() == 8) check("single_nobubble", 64'(hist_cyc[7] - hist_cyc[0]), 64'd7);
        tick();
        check("single_idle", 64'(busy_o), 64'd0);

        // All four valid, FIFO draining every cycle.
        start_test();
        for (int k = 0; k < NR; k++) remaining[k] = 20;
        refill();
        for (int i = 0; i < 22; i++) tick();
        check("rr_count", 64'(hist.size() >= 20), 64'd1);
        for (int i = 0; i < 20 && i < hist.size(); i++)
            check($sformatf("rr_order%0d", i), 64'(hist[i]), 64'((i / MB) % NR));
        if (hist.size() >= 20) check("rr_nobubble", 64'(hist_cyc[19] - hist_cyc[0]), 64'd19);

        // Reset mid-burst for 2.5 ns, requesters keep holding their data.
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        #1.5;
        rst_n = 1'b1;
        fifo_q.delete();
        hist.delete();
        hist_cyc.delete();
        @(posedge clk);
        #1;
        refill();
        check("midrst_owner", 64'(owner_o), 64'd0);
        check("midrst_busy",  64'(busy_o),  64'd1);
        tick();
        check("midrst_first", 64'(hist.size() > 0 ? hist[0] : -1), 64'd0);

        // FIFO full: req1 attempts 6 pushes, no pops.
        start_test();
        remaining[1] = 6;
        pop_pct      = 0;
        refill();
        for (int i = 0; i < 5; i++) tick();
        check("full_count4", 64'(hist.size()), 64'd4);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_owner", 64'(owner_o),     64'd1);
            check("full_busy",  64'(busy_o),      64'd1);
            check("full_stall", 64'(hist.size()), 64'd4);
        end
        pop_pct = 100;
        tick();
        pop_pct = 0;
        tick();
        check("full_resume", 64'(hist.size()), 64'd5);
        tick();
        check("full_stall2", 64'(hist.size()), 64'd5);

        // Early release: req0 stops after 2 transfers while req3 waits.
        start_test();
        remaining[0] = 2;
        remaining[3] = 4;
        refill();
        for (int i = 0; i < 3; i++) tick();
        check("early_owner0", 64'(owner_o), 64'd0);
        tick();
        check("early_owner3", 64'(owner_o), 64'd3);
        for (int i = 0; i < 4; i++) tick();
        n0 = 0;
        foreach (hist[i]) if (hist[i] == 0) n0++;
        check("early_req0_count", 64'(n0), 64'd2);
        check("early_third", 64'(hist.size() > 2 ? hist[2] : -1), 64'd3);

        // Random duty on all requesters, 50 % pops.
        start_test();
        for (int k = 0; k < NR; k++) begin
            remaining[k] = 1000;
            duty[k]      = int'($urandom_range(100, 25));
        end
        pop_pct = 50;
        refill();
        for (int i = 0; i < 300; i++) tick();
        check("rand_max_wait", 64'(max_wait <= 3 * MB), 64'd1);
        check("rand_outstanding", 64'(sb.size()), 64'($countones(req_valid_i)));
        check("rand_progress", 64'(hist.size() > 50), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
